// File: rtl/trigger_sequencer.sv
// trigger_sequencer
//   Sequences one DAC/ADC acquisition after an asynchronous GPIO trigger:
//   optional pre-delay, a RUN phase that drives the DAC/ADC enables and mask
//   strobes, an optional post-delay, then a one-cycle DONE pulse.
//   Configuration is captured into shadow registers on the accepting trigger.
// Ports
//   clk, rst            fabric clock, asynchronous active-high reset
//   trigger_in          raw asynchronous trigger (rising edge starts a sequence)
//   abort               synchronous cancel of any sequence
//   clear_status        synchronous clear of trig_overrun
//   cfg_pre_delay       pre-delay length in cycles
//   cfg_run_cycles      RUN length in cycles
//   cfg_adc_cycles      number of leading RUN cycles with adc_run high
//   cfg_post_delay      post-delay length in cycles
//   cfg_mask_enable     enables mask_first / mask_last
//   dac_run, adc_run    run enables
//   mask_first/last     first / last RUN cycle strobes
//   run_index           0-based RUN cycle index, 0 outside RUN
//   busy, done, aborted status; done/aborted are one-cycle pulses
//   trig_overrun        sticky: trigger seen while busy
module trigger_sequencer #(
  parameter int CNT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger_in,
  input  logic                 abort,
  input  logic                 clear_status,
  input  logic [CNT_WIDTH-1:0] cfg_pre_delay,
  input  logic [CNT_WIDTH-1:0] cfg_run_cycles,
  input  logic [CNT_WIDTH-1:0] cfg_adc_cycles,
  input  logic [CNT_WIDTH-1:0] cfg_post_delay,
  input  logic                 cfg_mask_enable,
  output logic                 dac_run,
  output logic                 adc_run,
  output logic                 mask_first,
  output logic                 mask_last,
  output logic [CNT_WIDTH-1:0] run_index,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 trig_overrun
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_RUN, S_POST, S_DONE} state_t;

  // ---------------------------------------------------------------- trigger
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] fill_reg;
  logic                   hist_reg;
  logic                   trig_pulse;

  // The history flop comes out of reset high and only starts tracking once
  // the synchroniser has refilled with real samples. A trigger held high
  // across reset therefore needs to fall and rise again before it counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      fill_reg <= '0;
      hist_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], trigger_in};
      fill_reg <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
      if (fill_reg[SYNC_STAGES-1]) hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign trig_pulse = sync_reg[SYNC_STAGES-1] & ~hist_reg;

  // ---------------------------------------------------------------- FSM
  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [CNT_WIDTH-1:0] pre_reg, pre_next, run_reg, run_next;
  logic [CNT_WIDTH-1:0] adc_reg, adc_next, post_reg, post_next;
  logic                 mask_reg, mask_next;

  logic                 dac_run_next, adc_run_next, mask_first_next, mask_last_next;
  logic [CNT_WIDTH-1:0] run_index_next;
  logic                 busy_next, done_next, aborted_next, trig_overrun_next;

  // First phase with a nonzero length, in PRE, RUN, POST order.
  function automatic state_t first_phase(input logic [CNT_WIDTH-1:0] pre,
                                         input logic [CNT_WIDTH-1:0] run,
                                         input logic [CNT_WIDTH-1:0] post);
    if (pre != '0)       return S_PRE;
    else if (run != '0)  return S_RUN;
    else if (post != '0) return S_POST;
    else                 return S_DONE;
  endfunction

  // State register, phase counter, shadows and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      pre_reg      <= '0;
      run_reg      <= '0;
      adc_reg      <= '0;
      post_reg     <= '0;
      mask_reg     <= 1'b0;
      dac_run      <= 1'b0;
      adc_run      <= 1'b0;
      mask_first   <= 1'b0;
      mask_last    <= 1'b0;
      run_index    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      trig_overrun <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      pre_reg      <= pre_next;
      run_reg      <= run_next;
      adc_reg      <= adc_next;
      post_reg     <= post_next;
      mask_reg     <= mask_next;
      dac_run      <= dac_run_next;
      adc_run      <= adc_run_next;
      mask_first   <= mask_first_next;
      mask_last    <= mask_last_next;
      run_index    <= run_index_next;
      busy         <= busy_next;
      done         <= done_next;
      aborted      <= aborted_next;
      trig_overrun <= trig_overrun_next;
    end
  end

  // Next state. cnt_reg counts elapsed cycles within the current phase.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pre_next   = pre_reg;
    run_next   = run_reg;
    adc_next   = adc_reg;
    post_next  = post_reg;
    mask_next  = mask_reg;
    case (state_reg)
      S_IDLE: begin
        if (trig_pulse) begin
          pre_next   = cfg_pre_delay;
          run_next   = cfg_run_cycles;
          adc_next   = cfg_adc_cycles;
          post_next  = cfg_post_delay;
          mask_next  = cfg_mask_enable;
          cnt_next   = '0;
          state_next = first_phase(cfg_pre_delay, cfg_run_cycles, cfg_post_delay);
        end
      end
      S_PRE: begin
        if (cnt_reg == pre_reg - ONE) begin
          cnt_next   = '0;
          state_next = first_phase('0, run_reg, post_reg);
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end
      S_RUN: begin
        if (cnt_reg == run_reg - ONE) begin
          cnt_next   = '0;
          state_next = first_phase('0, '0, post_reg);
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end
      S_POST: begin
        if (cnt_reg == post_reg - ONE) begin
          cnt_next   = '0;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Abort beats everything, including a trigger arriving in IDLE.
    if (abort) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      pre_next   = pre_reg;
      run_next   = run_reg;
      adc_next   = adc_reg;
      post_next  = post_reg;
      mask_next  = mask_reg;
    end
  end

  // Outputs are decoded from the upcoming state and then registered, so they
  // line up with the state they describe.
  always_comb begin
    dac_run_next      = (state_next == S_RUN);
    run_index_next    = dac_run_next ? cnt_next : '0;
    adc_run_next      = dac_run_next && (cnt_next < adc_next);
    mask_first_next   = dac_run_next && mask_next && (cnt_next == '0);
    mask_last_next    = dac_run_next && mask_next && (cnt_next == run_next - ONE);
    busy_next         = (state_next != S_IDLE);
    done_next         = (state_next == S_DONE);
    aborted_next      = abort && (state_reg != S_IDLE);
    // Set has priority over clear.
    trig_overrun_next = (trig_pulse && (state_reg != S_IDLE)) ||
                        (trig_overrun && !clear_status);
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Testbench for trigger_sequencer: directed scenarios, a per-cycle reference
// model based on the sequence offset since the accepting trigger, and literal
// expectations on observed pulse counts and latencies.
module tb_trigger_sequencer;
  localparam int W  = 32;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         trigger_in = 1'b0, abort = 1'b0, clear_status = 1'b0;
  logic [W-1:0] cfg_pre_delay = '0, cfg_run_cycles = '0, cfg_adc_cycles = '0, cfg_post_delay = '0;
  logic         cfg_mask_enable = 1'b0;
  logic         dac_run, adc_run, mask_first, mask_last, busy, done, aborted, trig_overrun;
  logic [W-1:0] run_index;

  trigger_sequencer #(.CNT_WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .trigger_in(trigger_in), .abort(abort),
    .clear_status(clear_status),
    .cfg_pre_delay(cfg_pre_delay), .cfg_run_cycles(cfg_run_cycles),
    .cfg_adc_cycles(cfg_adc_cycles), .cfg_post_delay(cfg_post_delay),
    .cfg_mask_enable(cfg_mask_enable),
    .dac_run(dac_run), .adc_run(adc_run), .mask_first(mask_first),
    .mask_last(mask_last), .run_index(run_index), .busy(busy), .done(done),
    .aborted(aborted), .trig_overrun(trig_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // A sequence is described by its offset m_pos from the first busy cycle:
  // [0,pre) pre-delay, [pre,pre+run) RUN, [pre+run,total-1) post, total-1 done.
  bit          m_active = 0, m_abt = 0, m_ov = 0, m_mask = 0, m_pulse, m_ovset;
  longint      m_pos = 0, m_pre = 0, m_run = 0, m_adc = 0, m_post = 0, m_total = 0;
  logic [SS+1:0] m_h = '1;  // m_h[k]: trigger sample taken k edges ago

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_abt = 0; m_ov = 0; m_pos = 0;
      m_h = '1;  // a trigger level present at reset release counts as old
    end else begin
      m_h     = {m_h[SS:0], trigger_in};
      m_pulse = m_h[SS] & ~m_h[SS+1];
      m_ovset = 0;
      m_abt   = 0;
      if (m_active) begin
        if (m_pulse) m_ovset = 1;
        if (abort) begin
          m_active = 0; m_abt = 1;
        end else begin
          m_pos++;
          if (m_pos == m_total) m_active = 0;
        end
      end else if (m_pulse && !abort) begin
        m_pre  = longint'(cfg_pre_delay);
        m_run  = longint'(cfg_run_cycles);
        m_adc  = longint'(cfg_adc_cycles);
        m_post = longint'(cfg_post_delay);
        m_mask = cfg_mask_enable;
        m_total = m_pre + m_run + m_post + 1;
        m_pos = 0;
        m_active = 1;
      end
      if (m_ovset) m_ov = 1;
      else if (clear_status) m_ov = 0;
    end
  end

  // ---------------------------------------------------------------- compare
  bit     e_dac, e_adc, e_mf, e_ml, e_done;
  longint e_idx;
  int ncyc = 0, busy_cnt, dac_cnt, adc_cnt, mf_cnt, ml_cnt, done_cnt, abt_cnt, all4_cnt, busy_rise;
  int first_busy, first_dac, last_dac, done_at;
  bit prev_busy = 0, prev_dac = 0;

  task automatic clr_obs();
    busy_cnt = 0; dac_cnt = 0; adc_cnt = 0; mf_cnt = 0; ml_cnt = 0; done_cnt = 0;
    abt_cnt = 0; all4_cnt = 0; busy_rise = 0;
    first_busy = -1; first_dac = -1; last_dac = -1; done_at = -1;
  endtask

  always @(negedge clk) begin
    ncyc++;
    e_dac = 0; e_adc = 0; e_mf = 0; e_ml = 0; e_done = 0; e_idx = 0;
    if (m_active) begin
      if (m_pos >= m_pre && m_pos < m_pre + m_run) begin
        e_dac = 1;
        e_idx = m_pos - m_pre;
        e_adc = (e_idx < m_adc);
        e_mf  = m_mask && (e_idx == 0);
        e_ml  = m_mask && (e_idx == m_run - 1);
      end
      e_done = (m_pos == m_total - 1);
    end
    chk("busy", busy, m_active);
    chk("dac_run", dac_run, e_dac);
    chk("adc_run", adc_run, e_adc);
    chk("mask_first", mask_first, e_mf);
    chk("mask_last", mask_last, e_ml);
    chk("run_index", run_index, e_idx);
    chk("done", done, e_done);
    chk("aborted", aborted, m_abt);
    chk("trig_overrun", trig_overrun, m_ov);
    // observations for literal checks
    if (busy) busy_cnt++;
    if (busy && !prev_busy) begin busy_rise++; if (first_busy < 0) first_busy = ncyc; end
    if (dac_run) begin dac_cnt++; last_dac = ncyc; end
    if (dac_run && !prev_dac && first_dac < 0) first_dac = ncyc;
    if (adc_run) adc_cnt++;
    if (mask_first) mf_cnt++;
    if (mask_last) ml_cnt++;
    if (done) begin done_cnt++; done_at = ncyc; end
    if (aborted) abt_cnt++;
    if (dac_run && adc_run && mask_first && mask_last) all4_cnt++;
    prev_busy = busy;
    prev_dac  = dac_run;
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_cfg(input int pre, input int run, input int adc, input int post, input bit mask);
    cfg_pre_delay = W'(pre); cfg_run_cycles = W'(run); cfg_adc_cycles = W'(adc);
    cfg_post_delay = W'(post); cfg_mask_enable = mask;
  endtask

  int t;

  initial begin
    clr_obs();
    tick(3);
    rst = 1'b0;
    tick(6);

    // T1: full sequence with every phase
    set_cfg(3, 5, 2, 4, 1); clr_obs();
    trigger_in = 1; t = ncyc; tick(2); trigger_in = 0; tick(25);
    chk("t1_busy_latency", first_busy - t, 3);
    chk("t1_busy_len", busy_cnt, 13);
    chk("t1_dac_after_busy", first_dac - first_busy, 3);
    chk("t1_dac_len", dac_cnt, 5);
    chk("t1_adc_len", adc_cnt, 2);
    chk("t1_mask_first", mf_cnt, 1);
    chk("t1_mask_last", ml_cnt, 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_after_run", done_at - last_dac, 5);

    // T2: all counts zero
    set_cfg(0, 0, 0, 0, 0); clr_obs();
    trigger_in = 1; t = ncyc; tick(1); trigger_in = 0; tick(10);
    chk("t2_busy_len", busy_cnt, 1);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_dac_len", dac_cnt, 0);
    chk("t2_busy_latency", first_busy - t, 3);

    // T3: single-cycle run, adc longer than run
    set_cfg(0, 1, 10, 0, 1); clr_obs();
    trigger_in = 1; tick(1); trigger_in = 0; tick(10);
    chk("t3_all_four", all4_cnt, 1);
    chk("t3_dac_len", dac_cnt, 1);
    chk("t3_adc_len", adc_cnt, 1);
    chk("t3_busy_len", busy_cnt, 2);

    // T4: retrigger and config change during RUN
    set_cfg(0, 5, 5, 0, 0); clr_obs();
    trigger_in = 1; tick(1); trigger_in = 0; tick(2);
    trigger_in = 1; tick(1); trigger_in = 0; cfg_run_cycles = W'(9); tick(20);
    chk("t4_dac_len", dac_cnt, 5);
    chk("t4_busy_len", busy_cnt, 6);
    chk("t4_busy_rises", busy_rise, 1);
    chk("t4_overrun_sticky", trig_overrun, 1);
    clear_status = 1; tick(1); clear_status = 0; tick(1);
    chk("t4_overrun_cleared", trig_overrun, 0);

    // T5a: abort at RUN index 2
    set_cfg(1, 5, 0, 2, 0); clr_obs();
    trigger_in = 1; tick(1); trigger_in = 0; tick(5);
    chk("t5_index_at_abort", run_index, 2);
    abort = 1; tick(1); abort = 0;
    chk("t5_dac_after_abort", dac_run, 0);
    tick(10);
    chk("t5_aborted_cnt", abt_cnt, 1);
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_dac_len", dac_cnt, 3);

    // T5b: abort coincident with a trigger in IDLE
    clr_obs();
    trigger_in = 1; tick(1); trigger_in = 0; tick(1);
    abort = 1; tick(1); abort = 0; tick(10);
    chk("t5b_busy_len", busy_cnt, 0);
    chk("t5b_aborted_cnt", abt_cnt, 0);

    // T6: reset mid-PRE, trigger held high across reset
    set_cfg(10, 2, 1, 0, 0); clr_obs();
    trigger_in = 1; tick(5);
    chk("t6_busy_before_rst", busy, 1);
    rst = 1; #1;
    chk("t6_busy_async", busy, 0);
    chk("t6_dac_async", dac_run, 0);
    chk("t6_done_async", done, 0);
    tick(3); rst = 0; clr_obs(); tick(10);
    chk("t6_no_seq_held_high", busy_cnt, 0);
    trigger_in = 0; tick(4); clr_obs();
    trigger_in = 1; tick(20);
    chk("t6_busy_len", busy_cnt, 13);
    chk("t6_dac_len", dac_cnt, 2);
    chk("t6_adc_len", adc_cnt, 1);
    chk("t6_busy_rises", busy_rise, 1);
    trigger_in = 0; tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
